// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Constants and helpers shared by the FIFO family (param_fifo and future
// variants).
//   FIFO_DATA_W_DEF : default word width in bits
//   FIFO_DEPTH_DEF  : default entry count
//   fifo_cnt_w()    : width of an occupancy counter able to hold 0..depth
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_DATA_W_DEF = 8;
  localparam int FIFO_DEPTH_DEF  = 8;

  // The occupancy must represent DEPTH itself, hence one bit beyond the
  // address width.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// DEPTH x DATA_W storage with one synchronous write port and one
// asynchronous read port. The array has no reset.
// Ports:
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // A read of the slot being written in the same cycle returns the old
  // word; the full-FIFO pass-through relies on this.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_fifo.sv
// -----------------------------------------------------------------------------
// param_fifo
// Synchronous single-clock FIFO with occupancy count, almost-full/empty
// thresholds and sticky overflow/underflow flags.
//
// Build option: define PARAM_FIFO_FWFT_EN for first-word-fall-through
// (data_out shows the head word whenever the FIFO is not empty, 0 when
// empty). Without it data_out is a register loaded with the head word on
// the edge that accepts a read (one cycle latency) and held otherwise.
//
// Handshake: wr and rd are request strobes sampled on every rising edge.
// A write is taken when wr && (!full || rd); a read is taken when
// rd && !empty. A request that is not taken has no effect on pointers,
// count, memory or data_out; it only raises the matching sticky error
// flag (overflow for wr&&full&&!rd, underflow for rd&&empty).
//
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   wr, data_in    : push request and data
//   rd             : pop request
//   err_clr        : clears overflow/underflow (a new error wins)
//   data_out       : read data
//   empty, full    : count==0, count==DEPTH
//   almost_empty   : count<=AE_LVL
//   almost_full    : count>=AF_LVL
//   fifo_cnt       : occupancy 0..DEPTH
//   overflow, underflow : sticky error flags
// -----------------------------------------------------------------------------
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr,
  input  logic                          rd,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          err_clr,
  output logic [DATA_W-1:0]             data_out,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_empty,
  output logic                          almost_full,
  output logic [fifo_cnt_w(DEPTH)-1:0]  fifo_cnt,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_cnt_w(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);

  // Elaboration-time parameter checks.
  if (DATA_W < 1) begin : g_bad_width
    $error("param_fifo: DATA_W must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("param_fifo: DEPTH must be a power of two >= 2");
  end
  if (AF_LVL < 1 || AF_LVL > DEPTH - 1) begin : g_bad_af
    $error("param_fifo: AF_LVL must be in 1..DEPTH-1");
  end
  if (AE_LVL < 1 || AE_LVL > DEPTH - 1) begin : g_bad_ae
    $error("param_fifo: AE_LVL must be in 1..DEPTH-1");
  end

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              wa, ra;
  logic [DATA_W-1:0] head;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wa),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  // Status decodes of the registered count.
  assign empty        = (cnt_q == '0);
  assign full         = (cnt_q == DEPTH_C);
  assign almost_empty = (cnt_q <= AE_C);
  assign almost_full  = (cnt_q >= AF_C);
  assign fifo_cnt     = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // A full FIFO still takes a write when a read frees the slot the same
  // cycle; an empty FIFO never takes a read, even alongside a write.
  assign wa = wr && (!full || rd);
  assign ra = rd && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (wa) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (ra) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (wa && !ra) begin
      cnt_d = cnt_q + CW'(1);
    end else if (ra && !wa) begin
      cnt_d = cnt_q - CW'(1);
    end

    // A fresh error takes priority over a simultaneous clear.
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wr && full && !rd) begin
      ovf_d = 1'b1;
    end
    if (rd && empty) begin
      udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

`ifdef PARAM_FIFO_FWFT_EN
  // Head word falls through; forced to zero while nothing is stored.
  assign data_out = empty ? '0 : head;
`else
  logic [DATA_W-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (ra) begin
      dout_d = head;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign data_out = dout_q;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// -----------------------------------------------------------------------------
// tb_param_fifo
// Two param_fifo instances share one stimulus stream: A uses the defaults
// (DATA_W=8, DEPTH=8, AF=6, AE=2), B uses DATA_W=16, DEPTH=4 (AF=2, AE=2).
// A queue-based model of each FIFO is advanced on every rising edge and a
// compare process checks all outputs of both instances on every falling
// edge. Directed sequences add literal expectations; a random phase follows.
// -----------------------------------------------------------------------------
module tb_param_fifo;

  // ---------------- clock / reset / stimulus signals ----------------
  logic        clk;
  logic        rst;
  logic        wr;
  logic        rd;
  logic        err_clr;
  logic [15:0] din;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: defaults ----------------
  logic [7:0] a_dout;
  logic       a_empty, a_full, a_ae, a_af, a_ov, a_un;
  logic [3:0] a_cnt;

  param_fifo u_a (
    .clk          (clk),
    .rst          (rst),
    .wr           (wr),
    .rd           (rd),
    .data_in      (din[7:0]),
    .err_clr      (err_clr),
    .data_out     (a_dout),
    .empty        (a_empty),
    .full         (a_full),
    .almost_empty (a_ae),
    .almost_full  (a_af),
    .fifo_cnt     (a_cnt),
    .overflow     (a_ov),
    .underflow    (a_un)
  );

  // ---------------- DUT B: DEPTH=4, DATA_W=16 ----------------
  logic [15:0] b_dout;
  logic        b_empty, b_full, b_ae, b_af, b_ov, b_un;
  logic [2:0]  b_cnt;

  param_fifo #(.DATA_W(16), .DEPTH(4)) u_b (
    .clk          (clk),
    .rst          (rst),
    .wr           (wr),
    .rd           (rd),
    .data_in      (din),
    .err_clr      (err_clr),
    .data_out     (b_dout),
    .empty        (b_empty),
    .full         (b_full),
    .almost_empty (b_ae),
    .almost_full  (b_af),
    .fifo_cnt     (b_cnt),
    .overflow     (b_ov),
    .underflow    (b_un)
  );

  // ---------------- scoreboard / model state ----------------
  logic [15:0] exp_qa[$];
  logic [15:0] exp_qb[$];
  logic [15:0] last_a, last_b;   // last popped word (registered-output build)
  bit          ova, una, ovb, unb;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_qa.delete();
    exp_qb.delete();
    last_a = '0;
    last_b = '0;
    ova = 0; una = 0; ovb = 0; unb = 0;
  endtask

  // FIFO rules for one instance given its current occupancy.
  task automatic rules(input int depth, input int size,
                       output bit push, output bit pop, output bit ovs, output bit uns);
    push = wr && (size < depth || rd);
    pop  = rd && size > 0;
    ovs  = wr && size == depth && !rd;
    uns  = rd && size == 0;
  endtask

  task automatic model_edge();
    bit push, pop, ovs, uns;
    if (rst) return;
    rules(8, exp_qa.size(), push, pop, ovs, uns);
    if (pop)  last_a = exp_qa.pop_front();
    if (push) exp_qa.push_back({8'h00, din[7:0]});
    ova = ovs | (ova & !err_clr);
    una = uns | (una & !err_clr);
    rules(4, exp_qb.size(), push, pop, ovs, uns);
    if (pop)  last_b = exp_qb.pop_front();
    if (push) exp_qb.push_back(din);
    ovb = ovs | (ovb & !err_clr);
    unb = uns | (unb & !err_clr);
  endtask

  task automatic compare_all();
    logic [15:0] ea, eb;
    int na, nb;
    na = exp_qa.size();
    nb = exp_qb.size();
`ifdef PARAM_FIFO_FWFT_EN
    ea = (na > 0) ? exp_qa[0] : 16'h0;
    eb = (nb > 0) ? exp_qb[0] : 16'h0;
`else
    ea = last_a;
    eb = last_b;
`endif
    chk("a_cnt",   32'(a_cnt),   32'(na));
    chk("a_empty", 32'(a_empty), 32'(na == 0));
    chk("a_full",  32'(a_full),  32'(na == 8));
    chk("a_ae",    32'(a_ae),    32'(na <= 2));
    chk("a_af",    32'(a_af),    32'(na >= 6));
    chk("a_ov",    32'(a_ov),    32'(ova));
    chk("a_un",    32'(a_un),    32'(una));
    chk("a_dout",  32'(a_dout),  32'(ea[7:0]));
    chk("b_cnt",   32'(b_cnt),   32'(nb));
    chk("b_empty", 32'(b_empty), 32'(nb == 0));
    chk("b_full",  32'(b_full),  32'(nb == 4));
    chk("b_ae",    32'(b_ae),    32'(nb <= 2));
    chk("b_af",    32'(b_af),    32'(nb >= 2));
    chk("b_ov",    32'(b_ov),    32'(ovb));
    chk("b_un",    32'(b_un),    32'(unb));
    chk("b_dout",  32'(b_dout),  32'(eb));
  endtask

  // Compare process: outputs are settled mid-cycle.
  always @(negedge clk) begin
    compare_all();
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic w, input logic r, input logic [15:0] d, input logic c);
    wr = w; rd = r; din = d; err_clr = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Returns the word a read delivers: the head before the edge in FWFT,
  // the registered output after the edge otherwise.
  task automatic do_read(output logic [15:0] va, output logic [15:0] vb);
`ifdef PARAM_FIFO_FWFT_EN
    va = {8'h00, a_dout};
    vb = b_dout;
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
`else
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    va = {8'h00, a_dout};
    vb = b_dout;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_reset_lits(input string tag);
    chk({tag, "_cnt"},   32'(a_cnt),   32'd0);
    chk({tag, "_empty"}, 32'(a_empty), 32'd1);
    chk({tag, "_ae"},    32'(a_ae),    32'd1);
    chk({tag, "_full"},  32'(a_full),  32'd0);
    chk({tag, "_af"},    32'(a_af),    32'd0);
    chk({tag, "_dout"},  32'(a_dout),  32'd0);
    chk({tag, "_ov"},    32'(a_ov),    32'd0);
    chk({tag, "_un"},    32'(a_un),    32'd0);
  endtask

  // Watchdog: the run is fixed-length, this only guards against a hang.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] va, vb, dat;
    wr = 0; rd = 0; err_clr = 0; din = '0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    #1;
    chk_reset_lits("rst0");
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Fill A with 0x01..0x08; almost_full appears at count 6.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 16'(i), 1'b0);
      if (i == 5) chk("af_at5", 32'(a_af), 32'd0);
      if (i == 6) chk("af_at6", 32'(a_af), 32'd1);
    end
    chk("fill_full", 32'(a_full), 32'd1);
    chk("fill_cnt",  32'(a_cnt),  32'd8);

    // Drain in order.
    for (int i = 1; i <= 8; i++) begin
      do_read(va, vb);
      chk("drain_data", 32'(va), 32'(i));
    end
    chk("drain_empty", 32'(a_empty), 32'd1);
    cyc(1'b0, 1'b0, 16'h0, 1'b1);

    // Full pass-through: write+read on a full FIFO.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 16'(8'h11 + i), 1'b0);
    cyc(1'b1, 1'b1, 16'h00AA, 1'b0);
    chk("pass_cnt", 32'(a_cnt), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      do_read(va, vb);
      if (i == 8) chk("pass_aa", 32'(va), 32'h0AA);
    end

    // Sticky errors, set-wins-over-clear, then clear.
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    chk("udf_set", 32'(a_un),  32'd1);
    chk("udf_cnt", 32'(a_cnt), 32'd0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 16'(8'h40 + i), 1'b0);
    cyc(1'b1, 1'b0, 16'h0099, 1'b0);
    chk("ovf_set", 32'(a_ov),  32'd1);
    chk("ovf_cnt", 32'(a_cnt), 32'd8);
    cyc(1'b1, 1'b0, 16'h0077, 1'b1);
    chk("ovf_set_wins", 32'(a_ov), 32'd1);
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    chk("clr_ov", 32'(a_ov), 32'd0);
    chk("clr_un", 32'(a_un), 32'd0);

    // 20 interleaved write/read pairs: pointer wrap on B (DEPTH 4).
    do_reset();
    for (int i = 0; i < 20; i++) begin
      dat = 16'(16'h00A1 + i * 16'h0357);
      cyc(1'b1, 1'b0, dat, 1'b0);
      do_read(va, vb);
      chk("wrap_b_data", 32'(vb), 32'(dat));
      chk("wrap_a_data", 32'(va), 32'(dat[7:0]));
    end
    chk("wrap_b_ov", 32'(b_ov), 32'd0);
    chk("wrap_b_un", 32'(b_un), 32'd0);

    // Asynchronous reset mid-burst at count 5.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 16'(8'h31 + i), 1'b0);
    do_read(va, vb);
    chk("burst_cnt", 32'(a_cnt), 32'd5);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk_reset_lits("arst");
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Write 0x55 into empty FIFO, no read.
    cyc(1'b1, 1'b0, 16'h0055, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
`ifdef PARAM_FIFO_FWFT_EN
    chk("fwft_55", 32'(a_dout), 32'h55);
`else
    chk("std_hold0", 32'(a_dout), 32'h00);
`endif

    // Random phase: write-heavy, read-heavy, then balanced.
    for (int i = 0; i < 600; i++) begin
      int wp, rp;
      wp = (i < 200) ? 75 : (i < 400) ? 25 : 50;
      rp = (i < 200) ? 25 : (i < 400) ? 75 : 50;
      cyc(1'($urandom_range(0, 99) < wp), 1'($urandom_range(0, 99) < rp),
          16'($urandom), 1'($urandom_range(0, 15) == 0));
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
